// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Latency: lw 5, sw/R/imm 4, beq/j 3 cycles; outputs decoded from current state each cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0 (when MEM_HANDSHAKE=1).
// Optional feature macro: MC_CONTROLLER_BNE_EN (adds bne through the BRANCH state).
module mc_controller #(
    parameter int ALUCTRL_W     = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic                 extop,
    output logic [1:0]           pcsrc,
    output logic                 pcen,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t     cur_state;
    state_t     nxt_state;
    logic       rdy;
    logic       pcwrite;
    logic       branch;
    logic       taken;
    logic       irwrite_raw;
    logic       memwrite_raw;
    logic       regwrite_raw;
    logic       illegal_raw;
    logic [3:0] alu_op;

    // With the handshake disabled every memory access completes in one cycle.
    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_FETCH;
        else        cur_state <= nxt_state;
    end

    // Next-state and Moore output decode.
    always_comb begin
        nxt_state    = S_FETCH;
        iord         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        extop        = 1'b1;
        pcsrc        = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        taken        = 1'b0;
        illegal_raw  = 1'b0;
        alu_op       = ALU_ADD;
        case (cur_state)
            S_FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = rdy;
                pcwrite     = rdy;
                nxt_state   = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:             nxt_state = S_MEMADR;
                    OP_RTYPE:                 nxt_state = S_EXECUTE;
                    OP_BEQ:                   nxt_state = S_BRANCH;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:                   nxt_state = S_BRANCH;
`endif
                    OP_ADDI, OP_ORI, OP_SLTI: nxt_state = S_IMMEX;
                    OP_J:                     nxt_state = S_JUMP;
                    default: begin
                        nxt_state   = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                nxt_state = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            S_MEMWR: begin
                // Write enable stays up for the whole wait.
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                nxt_state    = rdy ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100000: begin alu_op = ALU_ADD; nxt_state = S_ALUWB; end
                    6'b100010: begin alu_op = ALU_SUB; nxt_state = S_ALUWB; end
                    6'b100100: begin alu_op = ALU_AND; nxt_state = S_ALUWB; end
                    6'b100101: begin alu_op = ALU_OR;  nxt_state = S_ALUWB; end
                    6'b101010: begin alu_op = ALU_SLT; nxt_state = S_ALUWB; end
                    default:   illegal_raw = 1'b1;
                endcase
            end
            S_ALUWB: begin
                regwrite_raw = 1'b1;
                regdst       = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                alu_op  = ALU_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
`ifdef MC_CONTROLLER_BNE_EN
                taken   = zero ^ (opcode == OP_BNE);
`else
                taken   = zero;
`endif
            end
            S_IMMEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = S_IMMWB;
                case (opcode)
                    OP_ORI:  begin alu_op = ALU_OR; extop = 1'b0; end
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_IMMWB: begin
                regwrite_raw = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    // Zero-extend the 4-bit ALU code to the configured width.
    always_comb begin
        alucontrol      = '0;
        alucontrol[3:0] = alu_op;
    end

    // Write enables and the illegal pulse are suppressed for as long as reset is held.
    assign pcen     = rst_n & (pcwrite | (branch & taken));
    assign irwrite  = rst_n & irwrite_raw;
    assign regwrite = rst_n & regwrite_raw;
    assign memwrite = rst_n & memwrite_raw;
    assign illegal  = rst_n & illegal_raw;
    assign state    = cur_state;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit; successor to the single-cycle controller.
- Same opcode/funct/zero decode, but implemented as a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a memory ready handshake, a parametrised ALU-control width and illegal-instruction detection.
- Sits between the instruction register and the multicycle datapath.

Parameters:
- ALUCTRL_W, 4, alucontrol width. Must be >= 4; bits above [3:0] are driven 0.
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register; stable from DECODE onward.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write enable.
- irwrite  out  1  instruction register load enable.
- regdst  out  1  register destination: 1 = rd, 0 = rt.
- memtoreg  out  1  writeback source: 1 = data register, 0 = ALUOut.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A: 0 = PC, 1 = A register.
- alusrcb  out  2  ALU B: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm << 2.
- extop  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC enable = pcwrite | (branch & taken).
- alucontrol  out  ALUCTRL_W  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- state  out  4  current FSM state, for debug.

Behaviour:
- Reset: rst_n low asynchronously forces state = FETCH (0). While rst_n is low, pcen, irwrite, regwrite, memwrite and illegal are forced 0. Reset mid-instruction aborts it with no write.
- Outputs are Moore, decoded from state. In every state, signals not listed below are 0, alucontrol = ADD, extop = 1.
- States, encodings, outputs and transitions:
  - FETCH(0): iord=0, alusrcb=01, pcsrc=00. irwrite = pcwrite = mem_ready. Stays in FETCH while mem_ready=0, else -> DECODE.
  - DECODE(1): alusrcb=11 (branch target into ALUOut). Next state by opcode:
    - 100011 / 101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000, 001101, 001010 -> IMMEX
    - 000010 -> JUMP
    - any other -> FETCH, with illegal=1 for that cycle.
  - MEMADR(2): alusrca=1, alusrcb=10. -> MEMRD for lw, MEMWR for sw.
  - MEMRD(3): iord=1. Holds until mem_ready, then -> MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=1, regdst=0. -> FETCH.
  - MEMWR(5): iord=1, memwrite=1. memwrite stays asserted while waiting for mem_ready, then -> FETCH.
  - EXECUTE(6): alusrca=1, alusrcb=00, alucontrol decoded from funct:
    - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT -> ALUWB.
    - Any other funct: illegal=1, -> FETCH, no writeback.
  - ALUWB(7): regwrite=1, regdst=1, memtoreg=0. -> FETCH.
  - BRANCH(8): alusrca=1, alusrcb=00, alucontrol=SUB, pcsrc=01, branch=1; taken = zero. -> FETCH.
  - IMMEX(9): alusrca=1, alusrcb=10.
    - addi: ADD, extop=1.
    - ori: OR, extop=0.
    - slti: SLT, extop=1.
    - -> IMMWB.
  - IMMWB(10): regwrite=1, regdst=0, memtoreg=0. -> FETCH.
  - JUMP(11): pcsrc=10, pcwrite=1. -> FETCH.
- Illegal state encodings 12-15 return to FETCH on the next clock.
- Cycles per instruction with mem_ready=1: lw 5, sw 4, R-type 4, addi/ori/slti 4, beq 3, j 3. Each cycle of mem_ready=0 adds one cycle to FETCH, MEMRD or MEMWR.
- pcen is combinational from state, zero and mem_ready.

Optional Feature:
- Macro: MC_CONTROLLER_BNE_EN.
- Defined: opcode 000101 goes DECODE -> BRANCH, with taken = ~zero for that instruction; all other BRANCH outputs are unchanged.
- Undefined: 000101 is illegal (DECODE -> FETCH, illegal=1).

Test Plan:
- Reset: rst_n=0 mid-MEMWR with mem_ready=0 -> state=0, memwrite=0, pcen=0 immediately; after release with mem_ready=1, FETCH shows irwrite=1, pcen=1, alusrcb=01.
- R-type: opcode=000000, funct=100010, mem_ready=1 -> states 0,1,6,7,0; alucontrol=0110 in EXECUTE; regwrite=1 and regdst=1 in ALUWB. With funct=000000 -> illegal=1 in EXECUTE, then FETCH, regwrite never 1.
- lw with waits: opcode=100011, mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD -> 10 cycles total; irwrite pulses only on the ready cycle; memtoreg=1 and regwrite=1 in MEMWB.
- beq: opcode=000100, zero=1 -> pcen=1, pcsrc=01 in BRANCH. zero=0 -> pcen=0. With MC_CONTROLLER_BNE_EN, opcode=000101 gives the inverse result.
- Immediates: ori -> IMMEX with alucontrol=0001, extop=0; slti -> 0111, extop=1; addi -> 0010. With ALUCTRL_W=6, the upper two bits of alucontrol are 0.
- j and illegal: opcode=000010 -> JUMP with pcsrc=10, pcen=1, 3 cycles. opcode=111111 -> illegal=1 in DECODE, back to FETCH, no write enables asserted.
